// File: rtl/binary_game_display_if.sv
// Game-side/board-side signal bundle for binary_game_display.
// The slave modport is the display block; the master modport is whoever drives
// the game outputs and watches the board pins.
interface binary_game_display_if;
    logic [7:0]  value_in;
    logic [7:0]  score_in;
    logic        show_value;
    logic        show_score;
    logic        wrong_in;
    logic [3:0]  An;
    logic [6:0]  ssd;
    logic        Dp;
    logic [11:0] bcd_out;
    logic        conv_busy;

    modport slave (
        input  value_in,
        input  score_in,
        input  show_value,
        input  show_score,
        input  wrong_in,
        output An,
        output ssd,
        output Dp,
        output bcd_out,
        output conv_busy
    );

    modport master (
        output value_in,
        output score_in,
        output show_value,
        output show_score,
        output wrong_in,
        input  An,
        input  ssd,
        input  Dp,
        input  bcd_out,
        input  conv_busy
    );
endinterface

// File: rtl/binary_game_display.sv
// binary_game_display: renders the game's 8-bit number or score in decimal on
// a 4-digit multiplexed seven-segment display.
//  - Sequential double-dabble converter (IDLE -> SHIFT x8 -> DONE) produces BCD.
//  - Free-running refresh counter scans the anodes; An and ssd are registered
//    on the same edge.
//  - Optional leading-zero blanking: define BINARY_GAME_DISP_LZB_EN.
module binary_game_display #(
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic                  Clk,
    input  logic                  Reset,
    binary_game_display_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [REFRESH_BITS-1:0] SCAN_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_S     = 7'b0010010;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;

    // Converter state
    logic [1:0]  state;
    logic [7:0]  snapshot;
    logic [11:0] scratch;
    logic [2:0]  bit_cnt;
    logic        first_cycle;
    logic [11:0] bcd_q;
    logic        busy_q;

    // Display state
    logic [REFRESH_BITS-1:0] scan_cnt;
    logic [3:0]              an_q;
    logic [6:0]              ssd_q;

    // Combinational helpers
    logic [7:0]  src;
    logic [11:0] adjusted;
    logic [11:0] shifted;
    logic [1:0]  digit_idx;
    logic        hundreds_blank;
    logic        tens_blank;
    logic        display_on;
    logic [3:0]  next_an;
    logic [6:0]  next_ssd;

    // Seven-segment glyph for one BCD digit, {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // after the shift, so pre-add 3
    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // Source select and one double-dabble step on the scratch register
    always_comb begin
        src      = bus.show_score ? bus.score_in : bus.value_in;
        adjusted = {dabble(scratch[11:8]), dabble(scratch[7:4]), dabble(scratch[3:0])};
        shifted  = {adjusted[10:0], snapshot[3'd7 - bit_cnt]};
    end

    // Converter FSM: snapshot the source on change, shift 8 bits MSB first,
    // then publish the result
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            snapshot    <= '0;
            scratch     <= '0;
            bit_cnt     <= '0;
            first_cycle <= 1'b1;
            bcd_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((src != snapshot) || first_cycle) begin
                        snapshot    <= src;
                        scratch     <= '0;
                        bit_cnt     <= '0;
                        busy_q      <= 1'b1;
                        first_cycle <= 1'b0;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch <= shifted;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_q  <= scratch;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pick the digit for the current scan slot from the last completed result
    always_comb begin
        digit_idx  = scan_cnt[REFRESH_BITS-1 -: 2];
        display_on = bus.show_value | bus.show_score;
`ifdef BINARY_GAME_DISP_LZB_EN
        hundreds_blank = (bcd_q[11:8] == 4'd0);
        tens_blank     = hundreds_blank && (bcd_q[7:4] == 4'd0);
`else
        hundreds_blank = 1'b0;
        tens_blank     = 1'b0;
`endif
        next_an  = 4'b1111;
        next_ssd = GLYPH_BLANK;
        if (display_on) begin
            next_an = ~(4'b0001 << digit_idx);
            case (digit_idx)
                2'd0: next_ssd = glyph(bcd_q[3:0]);
                2'd1: next_ssd = tens_blank ? GLYPH_BLANK : glyph(bcd_q[7:4]);
                2'd2: next_ssd = hundreds_blank ? GLYPH_BLANK : glyph(bcd_q[11:8]);
                default: begin
                    if (bus.show_score) begin
                        next_ssd = GLYPH_S;
                    end else if (bus.wrong_in) begin
                        next_ssd = GLYPH_E;
                    end else begin
                        next_ssd = GLYPH_BLANK;
                    end
                end
            endcase
        end
    end

    // Refresh counter and registered anode/segment outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            scan_cnt <= '0;
            an_q     <= 4'b1111;
            ssd_q    <= GLYPH_BLANK;
        end else begin
            scan_cnt <= scan_cnt + SCAN_ONE;
            an_q     <= next_an;
            ssd_q    <= next_ssd;
        end
    end

    assign bus.An        = an_q;
    assign bus.ssd       = ssd_q;
    assign bus.Dp        = 1'b1;
    assign bus.bcd_out   = bcd_q;
    assign bus.conv_busy = busy_q;

endmodule

// File: tb/tb_binary_game_display.sv
// Testbench for binary_game_display (REFRESH_BITS=4).
// Stimulus pushes the expected decimal value of each new source into a queue;
// a negedge monitor pops it when a conversion completes and also checks the
// scanned digits against a decimal model of the display.
module tb_binary_game_display;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    always #5 Clk = ~Clk;

    binary_game_display_if bus();

    binary_game_display #(.REFRESH_BITS(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          exp_q[$];
    int          last_src = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected glyph at display position pos for decimal value v
    function automatic logic [6:0] digit_model(input int pos, input int v,
                                               input bit ss, input bit sv, input bit w);
        bit lzb;
`ifdef BINARY_GAME_DISP_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        case (pos)
            0: return glyph(v % 10);
            1: return (lzb && v < 10) ? 7'b1111111 : glyph((v / 10) % 10);
            2: return (lzb && v < 100) ? 7'b1111111 : glyph(v / 100);
            default: begin
                if (ss) return 7'b0010010;
                if (sv && w) return 7'b0000110;
                return 7'b1111111;
            end
        endcase
    endfunction

    // Drive game outputs; a changed source means one more conversion to expect
    task automatic apply(input int v, input int s, input bit sv, input bit ss, input bit w);
        int src;
        bus.value_in   = v[7:0];
        bus.score_in   = s[7:0];
        bus.show_value = sv;
        bus.show_score = ss;
        bus.wrong_in   = w;
        src = ss ? s : v;
        if (src != last_src) begin
            exp_q.push_back(src);
            last_src = src;
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Monitor: conversion results, digit contents and scan timing
    bit       prev_busy = 1'b0;
    int       busy_cnt  = 0;
    int       disp      = 0;
    int       p_disp    = 0;
    bit       p_ss = 1'b0, p_sv = 1'b0, p_w = 1'b0;
    bit       skip      = 1'b1;
    logic [3:0] run_an  = 4'hF;
    int       run_len   = 0;
    bit       run_valid = 1'b0;

    always @(negedge Clk) begin
        int e, pos, zeros;
        if (Reset) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
            disp      = 0;
            p_disp    = 0;
            skip      = 1'b1;
            run_an    = 4'hF;
            run_len   = 0;
            run_valid = 1'b0;
        end else begin
            if (bus.conv_busy) busy_cnt++;
            if (prev_busy && !bus.conv_busy) begin
                check("busy_len", busy_cnt, 9);
                busy_cnt = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bcd_unexpected: got 0x%0h, expected no conversion at %0t",
                             bus.bcd_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("bcd_out", int'(bus.bcd_out), to_bcd(e));
                    disp = e;
                end
            end else begin
                check("bcd_hold", int'(bus.bcd_out), to_bcd(disp));
            end
            prev_busy = bus.conv_busy;

            if (skip) begin
                skip = 1'b0;
            end else begin
                if (!(p_ss || p_sv)) begin
                    check("an_off", int'(bus.An), 'hF);
                    check("ssd_off", int'(bus.ssd), 'h7F);
                end else begin
                    zeros = 0;
                    pos   = 0;
                    for (int i = 0; i < 4; i++) begin
                        if (!bus.An[i]) begin
                            zeros++;
                            pos = i;
                        end
                    end
                    check("an_onehot", zeros, 1);
                    check("ssd_digit", int'(bus.ssd), int'(digit_model(pos, p_disp, p_ss, p_sv, p_w)));
                end
                if (bus.An != run_an) begin
                    if (run_an != 4'hF && bus.An != 4'hF) begin
                        check("scan_order", int'(bus.An), int'({run_an[2:0], run_an[3]}));
                        if (run_valid) check("scan_len", run_len, 4);
                        run_valid = 1'b1;
                    end else begin
                        run_valid = 1'b0;
                    end
                    run_an  = bus.An;
                    run_len = 1;
                end else begin
                    run_len++;
                end
            end
            p_ss   = bus.show_score;
            p_sv   = bus.show_value;
            p_w    = bus.wrong_in;
            p_disp = disp;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, s;
        bus.value_in   = 8'd0;
        bus.score_in   = 8'd0;
        bus.show_value = 1'b0;
        bus.show_score = 1'b0;
        bus.wrong_in   = 1'b0;
        #2 Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("rst_an", int'(bus.An), 'hF);
        check("rst_ssd", int'(bus.ssd), 'h7F);
        check("rst_dp", int'(bus.Dp), 1);
        check("rst_bcd", int'(bus.bcd_out), 0);
        check("rst_busy", int'(bus.conv_busy), 0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        exp_q.push_back(0);
        hold(12);

        // 255 shown as 2,5,5
        apply(255, 0, 1'b1, 1'b0, 1'b0);
        hold(14);
        // score overrides value
        apply(255, 7, 1'b1, 1'b1, 1'b0);
        hold(14);
        // change during the third shift cycle: 100 completes, then 42
        apply(100, 7, 1'b1, 1'b0, 1'b0);
        hold(3);
        apply(42, 7, 1'b1, 1'b0, 1'b0);
        hold(24);
        // wrong marker with zero, then display off
        apply(0, 7, 1'b1, 1'b0, 1'b1);
        hold(14);
        apply(0, 7, 1'b0, 1'b0, 1'b1);
        hold(6);

        // asynchronous reset in the middle of a conversion
        apply(200, 7, 1'b1, 1'b0, 1'b0);
        hold(4);
        #3 Reset = 1'b1;
        #1;
        check("mid_rst_an", int'(bus.An), 'hF);
        check("mid_rst_ssd", int'(bus.ssd), 'h7F);
        check("mid_rst_bcd", int'(bus.bcd_out), 0);
        check("mid_rst_busy", int'(bus.conv_busy), 0);
        exp_q.delete();
        @(negedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b0;
        exp_q.push_back(last_src);
        hold(14);

        // randomized traffic
        for (int k = 0; k < 25; k++) begin
            v = $urandom_range(0, 255);
            s = $urandom_range(0, 255);
            apply(v, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            hold($urandom_range(12, 20));
        end
        apply(9, 0, 1'b1, 1'b0, 1'b0);
        hold(14);
        apply(9, 99, 1'b1, 1'b1, 1'b0);
        hold(20);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
